conv_kxk_stream: RTL

Parametrised streaming 2-D convolution engine, the generalised successor of the fixed 3x3 8-bit `conv_2d`. Each valid cycle it takes one column of K signed pixels and maintains a KxK sliding window. It convolves the window with a runtime-loaded KxK signed kernel and emits one fixed-point result with a `o_valid` strobe after a fixed 3-cycle pipeline. It sits between the frame line buffers and the output frame store in the image-processing datapath.

---
 rtl/conv_kxk_stream.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/conv_kxk_stream.sv
// Streaming KxK signed convolution: sliding window x runtime-loaded kernel, 3-stage pipeline.
// Define CONV_SAT_EN to clamp the result to OUT_W (with o_sat); otherwise the result wraps.
module conv_kxk_stream #(
    parameter int K         = 3,
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int OUT_W     = 8,
    parameter int FRAC_BITS = 7
) (
    input  logic                    clk,
    input  logic                    i_nrst,
    input  logic                    i_load_knl,
    input  logic                    i_data_valid,
    input  logic                    i_sol,
    input  logic [K*DATA_W-1:0]     i_data,
    output logic signed [OUT_W-1:0] o_pixel,
    output logic                    o_valid,
    output logic                    o_sat
);

    localparam int NP     = K * K;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + $clog2(NP);
    localparam int FILL_W = $clog2(K + 1);

    logic                    accept;
    logic [FILL_W-1:0]       fill_reg, fill_next;
    logic                    launch;
    logic                    tok_reg, s1_valid_reg, s2_valid_reg;
    logic [NP*COEF_W-1:0]    knl_flat;
    logic [NP*DATA_W-1:0]    win_flat;
    logic [NP*PROD_W-1:0]    prod_flat;
    logic signed [SUM_W-1:0] sum_reg, sum_next;
    logic signed [SUM_W:0]   rnd_sum, shifted;
    logic signed [OUT_W-1:0] pix_next;
    logic                    sat_next;

    assign accept = i_data_valid && !i_load_knl;

    // Kernel and window cells share one shift discipline: column 0 takes the
    // incoming lane, column c takes column c-1, so knl[r][c] always pairs with win[r][c].
    genvar gi, gj;
    generate
        for (gi = 0; gi < K; gi++) begin : g_row
            for (gj = 0; gj < K; gj++) begin : g_col
                localparam int IDX = gi * K + gj;
                logic signed [COEF_W-1:0] knl_reg, knl_in;
                logic signed [DATA_W-1:0] win_reg, win_in;
                logic signed [PROD_W-1:0] prod_reg;

                if (gj == 0) begin : g_head
                    assign knl_in = i_data[gi*DATA_W +: COEF_W];
                    assign win_in = i_data[gi*DATA_W +: DATA_W];
                end else begin : g_tail
                    assign knl_in = knl_flat[(IDX-1)*COEF_W +: COEF_W];
                    assign win_in = win_flat[(IDX-1)*DATA_W +: DATA_W];
                end

                always_ff @(posedge clk or negedge i_nrst) begin
                    if (!i_nrst) begin
                        knl_reg  <= '0;
                        win_reg  <= '0;
                        prod_reg <= '0;
                    end else begin
                        if (i_load_knl)
                            knl_reg <= knl_in;
                        if (accept)
                            win_reg <= win_in;
                        prod_reg <= PROD_W'(win_reg) * PROD_W'(knl_reg);
                    end
                end

                assign knl_flat[IDX*COEF_W +: COEF_W]  = knl_reg;
                assign win_flat[IDX*DATA_W +: DATA_W]  = win_reg;
                assign prod_flat[IDX*PROD_W +: PROD_W] = prod_reg;
            end
        end
    endgenerate

    always_comb begin
        fill_next = fill_reg;
        if (i_load_knl)
            fill_next = '0;
        else if (i_data_valid) begin
            if (i_sol)
                fill_next = FILL_W'(1);
            else if (fill_reg != FILL_W'(K))
                fill_next = fill_reg + 1'b1;
        end
        launch = accept && (fill_next == FILL_W'(K));
    end

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < NP; i++)
            sum_next = sum_next + SUM_W'($signed(prod_flat[i*PROD_W +: PROD_W]));
    end

    // One guard bit above the sum keeps the rounding add from overflowing.
    generate
        if (FRAC_BITS > 0) begin : g_round
            localparam logic signed [SUM_W:0] ROUND = (SUM_W+1)'(1) <<< (FRAC_BITS - 1);
            assign rnd_sum = (SUM_W+1)'(sum_reg) + ROUND;
        end else begin : g_noround
            assign rnd_sum = (SUM_W+1)'(sum_reg);
        end
    endgenerate

    assign shifted = rnd_sum >>> FRAC_BITS;

`ifdef CONV_SAT_EN
    localparam logic signed [SUM_W:0] OUT_MAX = (SUM_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W:0] OUT_MIN = -(SUM_W+1)'(2 ** (OUT_W - 1));

    always_comb begin
        pix_next = shifted[OUT_W-1:0];
        sat_next = 1'b0;
        if (shifted > OUT_MAX) begin
            pix_next = OUT_MAX[OUT_W-1:0];
            sat_next = 1'b1;
        end else if (shifted < OUT_MIN) begin
            pix_next = OUT_MIN[OUT_W-1:0];
            sat_next = 1'b1;
        end
    end
`else
    always_comb begin
        pix_next = shifted[OUT_W-1:0];
        sat_next = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            fill_reg     <= '0;
            tok_reg      <= 1'b0;
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            sum_reg      <= '0;
            o_pixel      <= '0;
            o_valid      <= 1'b0;
            o_sat        <= 1'b0;
        end else begin
            fill_reg     <= fill_next;
            tok_reg      <= launch;
            s1_valid_reg <= tok_reg;
            s2_valid_reg <= s1_valid_reg;
            sum_reg      <= sum_next;
            o_pixel      <= pix_next;
            o_valid      <= s2_valid_reg;
            o_sat        <= sat_next && s2_valid_reg;
        end
    end

endmodule
